// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: FIFO head handshake, sticky
// error flags with their clear pulse, and FIFO occupancy.
interface uart_rx_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic             frame_err;
   logic             overrun;
   logic             err_clr;
   logic [CNT_W-1:0] rx_count;

   modport master (
      output rx_data, rx_valid, frame_err, overrun, rx_count,
      input  rx_ready, err_clr
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overrun, rx_count,
      output rx_ready, err_clr
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a receive FIFO and sticky
// frame/overrun error flags.
module uart_rx #(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 8
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      ser_rx,
   uart_rx_if.master rx_if
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [15:0]      HALF_RELOAD = 16'(CLK_DIV / 2 - 1);
   localparam logic [15:0]      BIT_RELOAD  = 16'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ZERO_C      = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C       = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ONE     = {{(PTR_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   logic             sync1_r, sync2_r, rxs_s, rxs_prev_r;
   logic [1:0]       settle_r;
   logic             armed_r;
   state_t           state_r, state_next_s;
   logic [15:0]      bit_cnt_r, cnt_next_s;
   logic [2:0]       bit_idx_r, idx_next_s;
   logic [7:0]       shift_r, shift_next_s;
   logic             push_req_s, frame_set_s;

   logic [7:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
   logic [CNT_W-1:0] count_r, count_next_s;
   logic [7:0]       rx_data_r, head_next_s;
   logic             rx_valid_r, frame_err_r, overrun_r;
   logic             pop_s, full_s, push_ok_s, overrun_set_s;

   assign rxs_s = sync2_r;

   // Receive state machine: next state, bit counter and shift register.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = bit_cnt_r;
      idx_next_s   = bit_idx_r;
      shift_next_s = shift_r;
      push_req_s   = 1'b0;
      frame_set_s  = 1'b0;
      case (state_r)
         IDLE: begin
            // armed_r blocks a low line left over from reset being taken as a start edge
            if (armed_r && rxs_prev_r && !rxs_s) begin
               state_next_s = START;
               cnt_next_s   = HALF_RELOAD;
            end else begin
               cnt_next_s   = 16'd0;
            end
         end
         START: begin
            if (bit_cnt_r != 16'd0) begin
               cnt_next_s = bit_cnt_r - 16'd1;
            end else if (!rxs_s) begin
               state_next_s = DATA;
               cnt_next_s   = BIT_RELOAD;
               idx_next_s   = 3'd0;
            end else begin
               state_next_s = IDLE;
            end
         end
         DATA: begin
            if (bit_cnt_r != 16'd0) begin
               cnt_next_s = bit_cnt_r - 16'd1;
            end else begin
               shift_next_s = {rxs_s, shift_r[7:1]};
               cnt_next_s   = BIT_RELOAD;
               idx_next_s   = bit_idx_r + 3'd1;
               if (bit_idx_r == 3'd7) begin
                  state_next_s = STOP;
               end else begin
                  state_next_s = DATA;
               end
            end
         end
         STOP: begin
            if (bit_cnt_r != 16'd0) begin
               cnt_next_s = bit_cnt_r - 16'd1;
            end else if (rxs_s) begin
               push_req_s   = 1'b1;
               state_next_s = IDLE;
            end else begin
               frame_set_s  = 1'b1;
               state_next_s = BREAK;
            end
         end
         BREAK: begin
            if (rxs_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = BREAK;
            end
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = 16'd0;
         end
      endcase
   end

   // FIFO control: push/pop arbitration, occupancy and next head byte.
   always_comb begin
      pop_s         = rx_valid_r & rx_if.rx_ready;
      full_s        = (count_r == DEPTH_C);
      push_ok_s     = push_req_s & (!full_s | pop_s);
      overrun_set_s = push_req_s & full_s & !pop_s;
      case ({push_ok_s, pop_s})
         2'b10:   count_next_s = count_r + ONE_C;
         2'b01:   count_next_s = count_r - ONE_C;
         default: count_next_s = count_r;
      endcase
      if (pop_s) begin
         rd_next_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_next_s = rd_ptr_r;
      end
      // a byte landing in an effectively empty FIFO bypasses the memory read
      if (push_ok_s && (count_r == (pop_s ? ONE_C : ZERO_C))) begin
         head_next_s = shift_r;
      end else if (count_next_s != ZERO_C) begin
         head_next_s = mem_r[rd_next_s];
      end else begin
         head_next_s = 8'd0;
      end
   end

   // Synchronizer, receiver state, FIFO pointers and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r     <= 1'b1;
         sync2_r     <= 1'b1;
         rxs_prev_r  <= 1'b1;
         settle_r    <= 2'b00;
         armed_r     <= 1'b0;
         state_r     <= IDLE;
         bit_cnt_r   <= 16'd0;
         bit_idx_r   <= 3'd0;
         shift_r     <= 8'd0;
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= ZERO_C;
         rx_data_r   <= 8'd0;
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         sync1_r     <= ser_rx;
         sync2_r     <= sync1_r;
         rxs_prev_r  <= rxs_s;
         settle_r    <= {settle_r[0], 1'b1};
         armed_r     <= armed_r | (settle_r[1] & rxs_s);
         state_r     <= state_next_s;
         bit_cnt_r   <= cnt_next_s;
         bit_idx_r   <= idx_next_s;
         shift_r     <= shift_next_s;
         wr_ptr_r    <= push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
         rd_ptr_r    <= rd_next_s;
         count_r     <= count_next_s;
         rx_data_r   <= head_next_s;
         rx_valid_r  <= (count_next_s != ZERO_C);
         frame_err_r <= frame_set_s | (frame_err_r & !rx_if.err_clr);
         overrun_r   <= overrun_set_s | (overrun_r & !rx_if.err_clr);
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= shift_r;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   assign rx_if.rx_data   = rx_data_r;
   assign rx_if.rx_valid  = rx_valid_r;
   assign rx_if.frame_err = frame_err_r;
   assign rx_if.overrun   = overrun_r;
   assign rx_if.rx_count  = count_r;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=16, FIFO_DEPTH=4.
module tb_uart_rx;
   logic clk;
   logic reset;
   logic ser_rx;
   int   checks;
   int   errors;

   uart_rx_if #(.FIFO_DEPTH(4)) rx_if ();

   uart_rx #(.CLK_DIV(16), .FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .ser_rx(ser_rx),
      .rx_if (rx_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      ser_rx = 1'b0;
      repeat (16) tick();
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         repeat (16) tick();
      end
      ser_rx = stop_bit;
      repeat (16) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; ser_rx = 1'b1; rx_if.rx_ready = 1'b0; rx_if.err_clr = 1'b0;
      repeat (5) tick();
      checks++;
      if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 || rx_if.rx_count !== 3'd0 ||
          rx_if.frame_err !== 1'b0 || rx_if.overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b data=%h count=%0d ferr=%b ovr=%b, expected all zero",
                  rx_if.rx_valid, rx_if.rx_data, rx_if.rx_count, rx_if.frame_err, rx_if.overrun);
      end
      reset = 1'b0;
      repeat (20) tick();
      checks++;
      if (rx_if.rx_valid !== 1'b0 || rx_if.rx_count !== 3'd0) begin
         errors++;
         $display("FAIL idle_after_reset: valid=%b count=%0d, expected 0 0", rx_if.rx_valid, rx_if.rx_count);
      end
   endtask

   task automatic test_basic();
      int  lat;
      bit  found;
      lat = 0; found = 1'b0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            for (int n = 1; n <= 200 && !found; n++) begin
               tick();
               if (rx_if.rx_valid === 1'b1) begin found = 1'b1; lat = n; end
            end
         end
      join
      checks++;
      if (!found || lat > 156 || lat < 150) begin
         errors++;
         $display("FAIL basic_latency: found=%0b cycles=%0d, expected 150..156", found, lat);
      end
      checks++;
      if (rx_if.rx_data !== 8'hA5 || rx_if.frame_err !== 1'b0 || rx_if.rx_count !== 3'd1) begin
         errors++;
         $display("FAIL basic_data: data=%h ferr=%b count=%0d, expected a5 0 1",
                  rx_if.rx_data, rx_if.frame_err, rx_if.rx_count);
      end
      repeat (20) tick();
      checks++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'hA5) begin
         errors++;
         $display("FAIL basic_hold: valid=%b data=%h, expected 1 a5", rx_if.rx_valid, rx_if.rx_data);
      end
      rx_if.rx_ready = 1'b1;
      tick();
      checks++;
      if (rx_if.rx_valid !== 1'b0 || rx_if.rx_count !== 3'd0) begin
         errors++;
         $display("FAIL basic_pop: valid=%b count=%0d, expected 0 0", rx_if.rx_valid, rx_if.rx_count);
      end
      repeat (3) tick();
      rx_if.rx_ready = 1'b0;
      checks++;
      if (rx_if.rx_valid !== 1'b0 || rx_if.rx_count !== 3'd0) begin
         errors++;
         $display("FAIL empty_pop: valid=%b count=%0d, expected 0 0", rx_if.rx_valid, rx_if.rx_count);
      end
   endtask

   task automatic test_frame_err();
      // err_clr lands in the very cycle the low stop bit is sampled
      fork
         send_frame(8'h3C, 1'b0);
         begin
            repeat (154) tick();
            rx_if.err_clr = 1'b1;
            tick();
            rx_if.err_clr = 1'b0;
         end
      join
      checks++;
      if (rx_if.frame_err !== 1'b1 || rx_if.rx_valid !== 1'b0 || rx_if.rx_count !== 3'd0) begin
         errors++;
         $display("FAIL frame_err_set: ferr=%b valid=%b count=%0d, expected 1 0 0",
                  rx_if.frame_err, rx_if.rx_valid, rx_if.rx_count);
      end
      repeat (20) tick();
      rx_if.err_clr = 1'b1;
      tick();
      rx_if.err_clr = 1'b0;
      repeat (60) tick();
      checks++;
      if (rx_if.frame_err !== 1'b0 || rx_if.rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL break_quiet: ferr=%b valid=%b, expected 0 0", rx_if.frame_err, rx_if.rx_valid);
      end
      ser_rx = 1'b1;
      repeat (32) tick();
      send_frame(8'h81, 1'b1);
      checks++;
      if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h81 || rx_if.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL after_break: valid=%b data=%h ferr=%b, expected 1 81 0",
                  rx_if.rx_valid, rx_if.rx_data, rx_if.frame_err);
      end
      rx_if.rx_ready = 1'b1;
      tick();
      rx_if.rx_ready = 1'b0;
   endtask

   task automatic test_overrun();
      logic [7:0] exp_b;
      for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1);
      checks++;
      if (rx_if.rx_count !== 3'd4 || rx_if.overrun !== 1'b1 || rx_if.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL overrun_flag: count=%0d ovr=%b ferr=%b, expected 4 1 0",
                  rx_if.rx_count, rx_if.overrun, rx_if.frame_err);
      end
      for (int i = 0; i < 4; i++) begin
         exp_b = 8'(i + 1);
         checks++;
         if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== exp_b) begin
            errors++;
            $display("FAIL overrun_drain: valid=%b data=%h, expected 1 %h", rx_if.rx_valid, rx_if.rx_data, exp_b);
         end
         rx_if.rx_ready = 1'b1;
         tick();
         rx_if.rx_ready = 1'b0;
      end
      rx_if.err_clr = 1'b1;
      tick();
      rx_if.err_clr = 1'b0;
      checks++;
      if (rx_if.rx_count !== 3'd0 || rx_if.overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear: count=%0d ovr=%b, expected 0 0", rx_if.rx_count, rx_if.overrun);
      end
   endtask

   task automatic test_glitch();
      ser_rx = 1'b0;
      repeat (5) tick();
      ser_rx = 1'b1;
      repeat (200) tick();
      checks++;
      if (rx_if.rx_valid !== 1'b0 || rx_if.frame_err !== 1'b0 || rx_if.rx_count !== 3'd0) begin
         errors++;
         $display("FAIL glitch: valid=%b ferr=%b count=%0d, expected 0 0 0",
                  rx_if.rx_valid, rx_if.frame_err, rx_if.rx_count);
      end
      send_frame(8'h33, 1'b1);
      checks++;
      if (rx_if.rx_data !== 8'h33 || rx_if.rx_count !== 3'd1) begin
         errors++;
         $display("FAIL glitch_recover: data=%h count=%0d, expected 33 1", rx_if.rx_data, rx_if.rx_count);
      end
   endtask

   task automatic test_reset_midframe();
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (80) tick();
            reset = 1'b1;
            repeat (3) tick();
            checks++;
            if (rx_if.rx_count !== 3'd0 || rx_if.rx_valid !== 1'b0) begin
               errors++;
               $display("FAIL reset_flush: count=%0d valid=%b, expected 0 0", rx_if.rx_count, rx_if.rx_valid);
            end
            reset = 1'b0;
         end
      join
      // released while the line is low in the middle of a start bit
      fork
         send_frame(8'h00, 1'b1);
         begin
            repeat (4) tick();
            reset = 1'b1;
            repeat (4) tick();
            reset = 1'b0;
         end
      join
      repeat (20) tick();
      checks++;
      if (rx_if.rx_count !== 3'd0 || rx_if.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL stale_frame: count=%0d ferr=%b, expected 0 0", rx_if.rx_count, rx_if.frame_err);
      end
      send_frame(8'h5A, 1'b1);
      checks++;
      if (rx_if.rx_count !== 3'd1 || rx_if.rx_data !== 8'h5A || rx_if.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_then_5a: count=%0d data=%h ferr=%b, expected 1 5a 0",
                  rx_if.rx_count, rx_if.rx_data, rx_if.frame_err);
      end
      rx_if.rx_ready = 1'b1;
      tick();
      rx_if.rx_ready = 1'b0;
   endtask

   task automatic test_full_pop();
      logic [7:0] exp_b;
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
      checks++;
      if (rx_if.rx_count !== 3'd4 || rx_if.overrun !== 1'b0) begin
         errors++;
         $display("FAIL full_fill: count=%0d ovr=%b, expected 4 0", rx_if.rx_count, rx_if.overrun);
      end
      // rx_ready is high exactly during the cycle the fifth stop bit is sampled
      fork
         send_frame(8'h14, 1'b1);
         begin
            repeat (154) tick();
            checks++;
            if (rx_if.rx_count !== 3'd4) begin
               errors++;
               $display("FAIL full_before: count=%0d, expected 4", rx_if.rx_count);
            end
            rx_if.rx_ready = 1'b1;
            tick();
            rx_if.rx_ready = 1'b0;
            checks++;
            if (rx_if.rx_count !== 3'd4 || rx_if.overrun !== 1'b0 || rx_if.rx_data !== 8'h11) begin
               errors++;
               $display("FAIL full_push_pop: count=%0d ovr=%b data=%h, expected 4 0 11",
                        rx_if.rx_count, rx_if.overrun, rx_if.rx_data);
            end
         end
      join
      for (int i = 0; i < 4; i++) begin
         exp_b = 8'h11 + 8'(i);
         checks++;
         if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== exp_b) begin
            errors++;
            $display("FAIL full_drain: valid=%b data=%h, expected 1 %h", rx_if.rx_valid, rx_if.rx_data, exp_b);
         end
         rx_if.rx_ready = 1'b1;
         tick();
         rx_if.rx_ready = 1'b0;
      end
      checks++;
      if (rx_if.rx_count !== 3'd0 || rx_if.rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_empty: count=%0d valid=%b, expected 0 0", rx_if.rx_count, rx_if.rx_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_frame_err();
      test_overrun();
      test_glitch();
      rx_if.rx_ready = 1'b1;
      tick();
      rx_if.rx_ready = 1'b0;
      test_reset_midframe();
      test_full_pop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
